pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, memory-wait cycles before mem_timeout sets; legal range 1..255.
REQ-002 Parameter: CNT_W, default 16, width of the performance counters.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_src1, id_src2  in  4 each  register sources of the instruction in ID.
REQ-006 id_use_src1, id_use_src2  in  1 each  source is actually read.
REQ-007 exe_wb_en  in  1, exe_dest  in  4, exe_mem_read  in  1  describe the instruction in EXE.
REQ-008 mem_wb_en  in  1, mem_dest  in  4  describe the instruction in MEM.
REQ-009 fwd_en  in  1  forwarding unit active.
REQ-010 branch_taken  in  1  taken branch resolved in EXE.
REQ-011 mem_req  in  1  MEM stage performs a load/store; mem_ready  in  1  SRAM side done.
REQ-012 pc_freeze, ifid_freeze, idex_freeze, exmem_freeze  out  1 each  hold the PC / pipeline register.
REQ-013 ifid_flush, idex_flush, memwb_flush  out  1 each  load bubble into the register.
REQ-014 mem_timeout  out  1  sticky watchdog flag.
REQ-015 stall_cycles, flush_count  out  CNT_W each  saturating performance counters.

Function
REQ-016 hit(s) = use_s and ((exe_wb_en and s==exe_dest and (not fwd_en or exe_mem_read)) or (not fwd_en and mem_wb_en and s==mem_dest)); data_hazard = hit(src1) or hit(src2).
REQ-017 mem_stall = mem_req and not mem_ready, combinational, same-cycle effect in any state.
REQ-018 Priority: mem_stall > branch_taken > data_hazard; outputs are combinational from inputs and state.
REQ-019 mem_stall: all four freezes = 1, memwb_flush = 1, every other flush = 0; branch/hazard actions are deferred (inputs held by frozen stages).
REQ-020 branch_taken (no mem_stall): ifid_flush = 1, idex_flush = 1, all freezes = 0.
REQ-021 data_hazard (neither above): pc_freeze = 1, ifid_freeze = 1, idex_flush = 1, others 0.
REQ-022 Otherwise all outputs except counters/flag = 0.
REQ-023 FSM states RUN, MEM_WAIT; RUN->MEM_WAIT when mem_stall; MEM_WAIT->RUN when mem_ready (same cycle outputs unstalled); otherwise hold.
REQ-024 wait_cnt (8 bit) clears on entering MEM_WAIT from RUN, increments each MEM_WAIT cycle with mem_stall, saturates at 255.
REQ-025 mem_timeout sets on the edge where wait_cnt reaches TIMEOUT while mem_stall, stays 1 until rst.
REQ-026 stall_cycles increments each cycle pc_freeze = 1; flush_count increments each cycle REQ-020 applies; both saturate at all-ones, never wrap.
REQ-027 mem_stall and mem_ready may toggle every cycle; one-cycle waits leave FSM consistent (no spurious timeout).

Reset
REQ-028 rst sampled only at rising clk: state = RUN, wait_cnt = 0, mem_timeout = 0, stall_cycles = 0, flush_count = 0.
REQ-029 rst mid-MEM_WAIT returns to RUN next edge; combinational outputs still follow inputs while rst is high.
REQ-030 rst overrides all counter increments in the same cycle.

Structure
REQ-031 FSM state encoding and TIMEOUT default live in the shared pipeline package with other stage constants.
REQ-032 One sub-module, hazard_detect, holds the purely combinational REQ-016 compare; FSM, priority and counters stay in pipe_hazard_ctrl.

Verification
REQ-033 fwd_en=1, exe_mem_read=1, exe_dest=3, id_src1=3, use_src1=1 -> pc_freeze=ifid_freeze=idex_flush=1 one cycle, stall_cycles=1.
REQ-034 fwd_en=0, mem_wb_en=1, mem_dest=5, id_src2=5 -> hazard asserted; same with fwd_en=1 -> no hazard.
REQ-035 branch_taken=1 with simultaneous data hazard -> ifid_flush=idex_flush=1, pc_freeze=0, flush_count=1.
REQ-036 mem_req=1, mem_ready=0 for 4 cycles then 1 -> 4 cycles all freezes + memwb_flush, state MEM_WAIT, returns RUN, mem_timeout=0.
REQ-037 TIMEOUT=3, mem_ready held 0 for 5 cycles -> mem_timeout=1 from 4th edge onward until rst; rst pulse in MEM_WAIT -> RUN, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants and types for the hazard/stall controller.
// Holds the controller FSM encoding, the watchdog default and stage-level bundles.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned RegAddrW       = 4;
  localparam int unsigned WaitCntW       = 8;
  localparam int unsigned TimeoutDefault = 255;
  localparam int unsigned CntWDefault    = 16;

  typedef logic [RegAddrW-1:0] reg_addr_t;
  typedef logic [WaitCntW-1:0] wait_cnt_t;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
  } freeze_t;

  typedef struct packed {
    logic ifid;
    logic idex;
    logic memwb;
  } flush_t;

  function automatic wait_cnt_t wait_cnt_inc(wait_cnt_t cnt);
    return (cnt == '1) ? cnt : cnt + WaitCntW'(1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW hazard compare between the ID sources and the EXE/MEM destinations.
// A load in EXE always hazards; otherwise forwarding hides EXE and MEM producers.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [3:0] src1_i,
  input  logic [3:0] src2_i,
  input  logic       use_src1_i,
  input  logic       use_src2_i,
  input  logic       exe_wb_en_i,
  input  logic [3:0] exe_dest_i,
  input  logic       exe_mem_read_i,
  input  logic       mem_wb_en_i,
  input  logic [3:0] mem_dest_i,
  input  logic       fwd_en_i,
  output logic       data_hazard_o
);

  logic hit1, hit2;

  function automatic logic src_hit(logic use_s, reg_addr_t s, logic exe_wb_en, reg_addr_t exe_dest,
                                   logic exe_mem_read, logic mem_wb_en, reg_addr_t mem_dest,
                                   logic fwd_en);
    logic exe_hit, mem_hit;
    exe_hit = exe_wb_en && (s == exe_dest) && (!fwd_en || exe_mem_read);
    mem_hit = !fwd_en && mem_wb_en && (s == mem_dest);
    return use_s && (exe_hit || mem_hit);
  endfunction

  always_comb begin
    hit1 = src_hit(use_src1_i, src1_i, exe_wb_en_i, exe_dest_i, exe_mem_read_i, mem_wb_en_i,
                   mem_dest_i, fwd_en_i);
    hit2 = src_hit(use_src2_i, src2_i, exe_wb_en_i, exe_dest_i, exe_mem_read_i, mem_wb_en_i,
                   mem_dest_i, fwd_en_i);
  end

  assign data_hazard_o = hit1 || hit2;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline freeze/flush controller: memory stall > taken branch > data hazard,
// with a memory-wait watchdog and saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault,
  parameter int unsigned CNT_W   = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             exe_wb_en,
  input  logic [3:0]       exe_dest,
  input  logic             exe_mem_read,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             idex_freeze,
  output logic             exmem_freeze,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam wait_cnt_t TimeoutCnt = WaitCntW'(TIMEOUT);

  ctrl_state_e      state_q, state_d;
  wait_cnt_t        wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic    mem_stall, data_hazard, branch_flush;
  freeze_t freeze;
  flush_t  flush;

  hazard_detect u_hazard_detect (
    .src1_i         (id_src1),
    .src2_i         (id_src2),
    .use_src1_i     (id_use_src1),
    .use_src2_i     (id_use_src2),
    .exe_wb_en_i    (exe_wb_en),
    .exe_dest_i     (exe_dest),
    .exe_mem_read_i (exe_mem_read),
    .mem_wb_en_i    (mem_wb_en),
    .mem_dest_i     (mem_dest),
    .fwd_en_i       (fwd_en),
    .data_hazard_o  (data_hazard)
  );

  assign mem_stall    = mem_req && !mem_ready;
  assign branch_flush = branch_taken && !mem_stall;

  // Frozen stages hold their inputs, so branch/hazard actions simply replay after a stall.
  always_comb begin
    freeze = '0;
    flush  = '0;
    if (mem_stall) begin
      freeze      = '1;
      flush.memwb = 1'b1;
    end else if (branch_taken) begin
      flush.ifid = 1'b1;
      flush.idex = 1'b1;
    end else if (data_hazard) begin
      freeze.pc   = 1'b1;
      freeze.ifid = 1'b1;
      flush.idex  = 1'b1;
    end
  end

  assign pc_freeze    = freeze.pc;
  assign ifid_freeze  = freeze.ifid;
  assign idex_freeze  = freeze.idex;
  assign exmem_freeze = freeze.exmem;
  assign ifid_flush   = flush.ifid;
  assign idex_flush   = flush.idex;
  assign memwb_flush  = flush.memwb;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          state_d = StRun;
        end else if (mem_stall) begin
          wait_cnt_d = wait_cnt_inc(wait_cnt_q);
          if (wait_cnt_d == TimeoutCnt) begin
            mem_timeout_d = 1'b1;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (freeze.pc && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (branch_flush && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: a default instance (a) and a TIMEOUT=3, CNT_W=3 instance (b) share stimulus.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam logic [6:0] CtlNone  = 7'b0000_000;
  localparam logic [6:0] CtlMem   = 7'b1111_001;
  localparam logic [6:0] CtlBr    = 7'b0000_110;
  localparam logic [6:0] CtlHaz   = 7'b1100_010;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic id_use_src1, id_use_src2, exe_wb_en, exe_mem_read, mem_wb_en, fwd_en;
  logic branch_taken, mem_req, mem_ready;

  logic pcf_a, ifidf_a, idexf_a, exmemf_a, ifidfl_a, idexfl_a, memwbfl_a, to_a;
  logic pcf_b, ifidf_b, idexf_b, exmemf_b, ifidfl_b, idexfl_b, memwbfl_b, to_b;
  logic [15:0] stall_a, flush_a;
  logic [2:0]  stall_b, flush_b;
  logic [6:0]  ctl_a, ctl_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctl_a = {pcf_a, ifidf_a, idexf_a, exmemf_a, ifidfl_a, idexfl_a, memwbfl_a};
  assign ctl_b = {pcf_b, ifidf_b, idexf_b, exmemf_b, ifidfl_b, idexfl_b, memwbfl_b};

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1),
    .id_use_src2(id_use_src2), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
    .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .fwd_en(fwd_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pcf_a), .ifid_freeze(ifidf_a), .idex_freeze(idexf_a), .exmem_freeze(exmemf_a),
    .ifid_flush(ifidfl_a), .idex_flush(idexfl_a), .memwb_flush(memwbfl_a),
    .mem_timeout(to_a), .stall_cycles(stall_a), .flush_count(flush_a)
  );

  pipe_hazard_ctrl #(.TIMEOUT(3), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1),
    .id_use_src2(id_use_src2), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
    .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .fwd_en(fwd_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pcf_b), .ifid_freeze(ifidf_b), .idex_freeze(idexf_b), .exmem_freeze(exmemf_b),
    .ifid_flush(ifidfl_b), .idex_flush(idexfl_b), .memwb_flush(memwbfl_b),
    .mem_timeout(to_b), .stall_cycles(stall_b), .flush_count(flush_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_src1 = '0; id_src2 = '0; exe_dest = '0; mem_dest = '0;
    id_use_src1 = 1'b0; id_use_src2 = 1'b0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    mem_wb_en = 1'b0; fwd_en = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Check combinational controls for the current inputs, then clock one edge.
  task automatic step(input string tag, input logic [6:0] e);
    #1;
    chk({tag, "_ctl_a"}, 32'(ctl_a), 32'(e));
    chk({tag, "_ctl_b"}, 32'(ctl_b), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic cnt(input string tag, input int sa, input int fa, input int sb, input int fb);
    chk({tag, "_stall_a"}, 32'(stall_a), sa);
    chk({tag, "_flush_a"}, 32'(flush_a), fa);
    chk({tag, "_stall_b"}, 32'(stall_b), sb);
    chk({tag, "_flush_b"}, 32'(flush_b), fb);
  endtask

  task automatic st(input string tag, input ctrl_state_e e);
    chk({tag, "_state_a"}, 32'(dut_a.state_q), 32'(e));
    chk({tag, "_state_b"}, 32'(dut_b.state_q), 32'(e));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt("reset", 0, 0, 0, 0);
    st("reset", StRun);
    chk("reset_to_a", 32'(to_a), 0);
    chk("reset_to_b", 32'(to_b), 0);

    // Outputs follow inputs under reset, but the counters must not move.
    rst = 1'b1; branch_taken = 1'b1;
    step("rst_branch", CtlBr);
    cnt("rst_branch", 0, 0, 0, 0);
    rst = 1'b0; branch_taken = 1'b0;

    fwd_en = 1'b1; exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = 4'd3;
    id_src1 = 4'd3; id_use_src1 = 1'b1;
    step("load_use", CtlHaz);
    cnt("load_use", 1, 0, 1, 0);
    exe_mem_read = 1'b0;
    step("exe_fwd", CtlNone);
    cnt("exe_fwd", 1, 0, 1, 0);

    idle();
    mem_wb_en = 1'b1; mem_dest = 4'd5; id_src2 = 4'd5; id_use_src2 = 1'b1;
    step("mem_nofwd", CtlHaz);
    cnt("mem_nofwd", 2, 0, 2, 0);
    fwd_en = 1'b1;
    step("mem_fwd", CtlNone);
    fwd_en = 1'b0; id_use_src2 = 1'b0;
    step("mem_unused", CtlNone);
    id_use_src2 = 1'b1; mem_dest = 4'd6;
    step("mem_other", CtlNone);
    cnt("no_haz", 2, 0, 2, 0);

    idle();
    exe_wb_en = 1'b1; exe_dest = 4'd7; id_src1 = 4'd7; id_use_src1 = 1'b1;
    step("exe_nofwd", CtlHaz);
    exe_wb_en = 1'b0;
    step("exe_nowb", CtlNone);
    cnt("exe_haz", 3, 0, 3, 0);

    exe_wb_en = 1'b1; branch_taken = 1'b1;
    step("br_haz", CtlBr);
    cnt("br_haz", 3, 1, 3, 1);

    // Memory wait with a held taken branch; b's watchdog trips on the 4th edge.
    idle();
    branch_taken = 1'b1; mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("mwait", CtlMem);
      st("mwait", StMemWait);
      chk("mwait_to_a", 32'(to_a), 0);
      chk("mwait_to_b", 32'(to_b), (i == 3) ? 1 : 0);
    end
    cnt("mwait", 7, 1, 7, 1);
    mem_ready = 1'b1;
    step("mrelease", CtlBr);
    st("mrelease", StRun);
    cnt("mrelease", 7, 2, 7, 2);
    chk("mrelease_to_a", 32'(to_a), 0);
    chk("mrelease_to_b", 32'(to_b), 1);

    idle();
    mem_req = 1'b1;
    step("mwait2", CtlMem);
    st("mwait2", StMemWait);
    cnt("stall_sat", 8, 2, 7, 2);
    rst = 1'b1;
    step("rst_mwait", CtlMem);
    st("rst_mwait", StRun);
    cnt("rst_mwait", 0, 0, 0, 0);
    chk("rst_mwait_to_b", 32'(to_b), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step("tmo", CtlMem);
      chk("tmo_b", 32'(to_b), (i >= 3) ? 1 : 0);
      chk("tmo_a", 32'(to_a), 0);
    end
    mem_ready = 1'b1;
    step("tmo_rel", CtlNone);
    st("tmo_rel", StRun);
    chk("tmo_sticky_b", 32'(to_b), 1);

    idle();
    rst = 1'b1;
    step("rst2", CtlNone);
    rst = 1'b0;
    chk("rst2_to_b", 32'(to_b), 0);

    // One-cycle waits alternating with ready must never accumulate toward the timeout.
    mem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b0;
      step("tog_stall", CtlMem);
      st("tog_stall", StMemWait);
      mem_ready = 1'b1;
      step("tog_ready", CtlNone);
      st("tog_ready", StRun);
    end
    chk("tog_to_b", 32'(to_b), 0);
    cnt("tog", 6, 0, 6, 0);

    idle();
    rst = 1'b1;
    step("rst3", CtlNone);
    rst = 1'b0;
    branch_taken = 1'b1;
    for (int i = 0; i < 10; i++) step("br_run", CtlBr);
    cnt("flush_sat", 0, 10, 0, 7);
    idle();
    mem_wb_en = 1'b1; mem_dest = 4'd5; id_src2 = 4'd5; id_use_src2 = 1'b1;
    for (int i = 0; i < 9; i++) step("haz_run", CtlHaz);
    cnt("haz_sat", 9, 10, 7, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
